// File: rtl/core_pkg.sv
// Shared core encodings: write-back result sources and load funct3 codes.
package core_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Byte/half-word/word lane extraction with sign or zero extension for loads.
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  logic [31:0] word;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign word      = raw[31:0];
  assign half_lane = addr_lo[1] ? word[31:16] : word[15:0];

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    byte_lane = word[7:0];
    case (addr_lo)
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      2'd3:    byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
  end

  // Size casts of signed operands sign-extend; unsigned ones zero-extend.
  always_comb begin
    case (funct3)
      F3_LB:   data = XLEN'($signed(byte_lane));
      F3_LBU:  data = XLEN'(byte_lane);
      F3_LH:   data = XLEN'($signed(half_lane));
      F3_LHU:  data = XLEN'(half_lane);
      default: data = XLEN'($signed(word));
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: selects the pipeline result, merges late MUL/DIV results
// through a small FIFO and requests a bubble when the queue head starves.
module writeback_unit
  import core_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_valid_i,
  input  logic                        reg_write_i,
  input  logic [1:0]                  result_src_i,
  input  logic [XLEN-1:0]             alu_result_i,
  input  logic [XLEN-1:0]             read_data_i,
  input  logic [XLEN-1:0]             pc_plus4_i,
  input  logic [XLEN-1:0]             imm_i,
  input  logic [2:0]                  load_funct3_i,
  input  logic [1:0]                  addr_lo_i,
  input  logic [REG_AW-1:0]           rd_i,
  input  logic                        late_valid_i,
  output logic                        late_ready_o,
  input  logic [REG_AW-1:0]           late_rd_i,
  input  logic [XLEN-1:0]             late_data_i,
  output logic                        reg_write_o,
  output logic [REG_AW-1:0]           rd_o,
  output logic [XLEN-1:0]             result_o,
  output logic                        stall_o,
  output logic [$clog2(LQ_DEPTH):0]   lq_count_o
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } lq_entry_t;

  lq_entry_t         lq_mem [LQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve;
  logic              pipe_wr;
  logic              empty;
  logic              full;
  logic              enq;
  logic              deq;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   pipe_result;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3  (load_funct3_i),
    .addr_lo (addr_lo_i),
    .raw     (read_data_i),
    .data    (load_data)
  );

  always_comb begin
    case (result_src_e'(result_src_i))
      RES_ALU:  pipe_result = alu_result_i;
      RES_LOAD: pipe_result = load_data;
      RES_PC4:  pipe_result = pc_plus4_i;
      RES_IMM:  pipe_result = imm_i;
      default:  pipe_result = alu_result_i;
    endcase
  end

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(LQ_DEPTH));
  assign late_ready_o = !full;
  assign lq_count_o   = count;
  assign stall_o      = (starve == STV_W'(STARVE_LIMIT));

  assign pipe_wr = wb_valid_i & reg_write_i & (rd_i != '0);
  // x0 results complete the handshake but are dropped instead of queued.
  assign enq     = late_valid_i & !full & (late_rd_i != '0);
  assign deq     = !pipe_wr & !empty;

  // NOTE: queue storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) lq_mem[wr_ptr] <= '{rd: late_rd_i, data: late_data_i};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve      <= '0;
      reg_write_o <= 1'b0;
      rd_o        <= '0;
      result_o    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;

      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (empty || deq)
        starve <= '0;
      else if (!stall_o)
        starve <= starve + 1'b1;

      // The pipeline always owns the port; the queue head only fills idle slots.
      if (pipe_wr) begin
        reg_write_o <= 1'b1;
        rd_o        <= rd_i;
        result_o    <= pipe_result;
      end else if (deq) begin
        reg_write_o <= 1'b1;
        rd_o        <= lq_mem[rd_ptr].rd;
        result_o    <= lq_mem[rd_ptr].data;
      end else begin
        reg_write_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios then random traffic
// against a queue-based reference model.
module tb_writeback_unit;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int LQ_DEPTH     = 4;
  localparam int STARVE_LIMIT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid_i;
  logic              reg_write_i;
  logic [1:0]        result_src_i;
  logic [XLEN-1:0]   alu_result_i;
  logic [XLEN-1:0]   read_data_i;
  logic [XLEN-1:0]   pc_plus4_i;
  logic [XLEN-1:0]   imm_i;
  logic [2:0]        load_funct3_i;
  logic [1:0]        addr_lo_i;
  logic [REG_AW-1:0] rd_i;
  logic              late_valid_i;
  logic              late_ready_o;
  logic [REG_AW-1:0] late_rd_i;
  logic [XLEN-1:0]   late_data_i;
  logic              reg_write_o;
  logic [REG_AW-1:0] rd_o;
  logic [XLEN-1:0]   result_o;
  logic              stall_o;
  logic [$clog2(LQ_DEPTH):0] lq_count_o;

  writeback_unit #(
    .XLEN(XLEN), .REG_AW(REG_AW), .LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid_i), .reg_write_i(reg_write_i), .result_src_i(result_src_i),
    .alu_result_i(alu_result_i), .read_data_i(read_data_i), .pc_plus4_i(pc_plus4_i),
    .imm_i(imm_i), .load_funct3_i(load_funct3_i), .addr_lo_i(addr_lo_i), .rd_i(rd_i),
    .late_valid_i(late_valid_i), .late_ready_o(late_ready_o), .late_rd_i(late_rd_i),
    .late_data_i(late_data_i), .reg_write_o(reg_write_o), .rd_o(rd_o),
    .result_o(result_o), .stall_o(stall_o), .lq_count_o(lq_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } ent_t;

  ent_t              m_q[$];
  int                m_starve;
  logic              m_we;
  logic [REG_AW-1:0] m_rd;
  logic [XLEN-1:0]   m_res;
  int                vectors;
  int                miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load value computed arithmetically from the lane rules.
  function automatic logic [31:0] ext_ref(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] pipe_ref();
    case (result_src_i)
      2'd0:    return alu_result_i;
      2'd1:    return ext_ref(load_funct3_i, addr_lo_i, read_data_i);
      2'd2:    return pc_plus4_i;
      default: return imm_i;
    endcase
  endfunction

  // One clock: check state-derived outputs, advance the model, check registered outputs.
  task automatic tick();
    bit pw, acc, dq;
    check("late_ready", late_ready_o, m_q.size() < LQ_DEPTH);
    check("stall", stall_o, m_starve >= STARVE_LIMIT);
    check("lq_count", lq_count_o, m_q.size());
    pw  = wb_valid_i && reg_write_i && rd_i != 0;
    acc = late_valid_i && m_q.size() < LQ_DEPTH;
    dq  = !pw && m_q.size() > 0;
    if (rst) begin
      m_q.delete();
      m_starve = 0;
      m_we = 1'b0; m_rd = '0; m_res = '0;
    end else begin
      if (pw) begin
        m_we = 1'b1; m_rd = rd_i; m_res = pipe_ref();
      end else if (dq) begin
        m_we = 1'b1; m_rd = m_q[0].rd; m_res = m_q[0].data;
      end else begin
        m_we = 1'b0;
      end
      if (m_q.size() == 0 || dq) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      if (dq) void'(m_q.pop_front());
      if (acc && late_rd_i != 0) m_q.push_back('{rd: late_rd_i, data: late_data_i});
    end
    @(posedge clk);
    #1;
    check("reg_write", reg_write_o, m_we);
    check("rd", rd_o, m_rd);
    check("result", result_o, m_res);
  endtask

  task automatic idle();
    wb_valid_i = 0; reg_write_i = 0; result_src_i = 0; rd_i = 0;
    late_valid_i = 0; late_rd_i = 0; late_data_i = 0;
  endtask

  task automatic pipe(input logic [1:0] src, input logic [REG_AW-1:0] rd);
    wb_valid_i = 1; reg_write_i = 1; result_src_i = src; rd_i = rd;
  endtask

  task automatic offer(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
    late_valid_i = 1; late_rd_i = rd; late_data_i = data;
  endtask

  initial begin
    logic [2:0] f3s [5];
    logic [1:0] adrs [5];
    logic [31:0] exps [5];
    vectors = 0; miscompares = 0;
    rst = 1; idle();
    alu_result_i = 0; read_data_i = 0; pc_plus4_i = 0; imm_i = 0;
    load_funct3_i = 0; addr_lo_i = 0;
    @(posedge clk); @(posedge clk); #1;
    m_q.delete(); m_starve = 0; m_we = 0; m_rd = 0; m_res = 0;
    check("rst_reg_write", reg_write_o, 1'b0);
    check("rst_rd", rd_o, 0);
    check("rst_result", result_o, 0);
    rst = 0;
    tick();

    // ALU write, then the same with rd=0
    pipe(2'd0, 5); alu_result_i = 32'h1234_5678; tick();
    check("alu_write", result_o, 32'h1234_5678);
    rd_i = 0; tick();
    check("x0_no_write", reg_write_o, 1'b0);

    // Load extraction on 0x80FF_7F01
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    adrs = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    exps = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    read_data_i = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      pipe(2'd1, 9); load_funct3_i = f3s[i]; addr_lo_i = adrs[i];
      tick();
      check("load_lane", result_o, exps[i]);
    end
    pc_plus4_i = 32'h0000_1004; pipe(2'd2, 1); tick();
    imm_i = 32'hABCD_E000; pipe(2'd3, 2); tick();

    // Late result through an idle pipeline: written two cycles later
    idle(); offer(7, 32'hDEAD_BEEF); tick();
    idle(); tick();
    tick();
    check("late_idle_rd", rd_o, 7);

    // Fill the queue under continuous pipeline writes, then starve the head
    alu_result_i = 32'h0000_0042; pipe(2'd0, 3);
    for (int i = 0; i < 5; i++) begin
      offer(REG_AW'(10 + i), 32'hC000_0000 + i);
      tick();
    end
    check("full_ready", late_ready_o, 1'b0);
    late_valid_i = 0;
    for (int i = 0; i < 6; i++) tick();
    check("starve_stall", stall_o, 1'b1);
    wb_valid_i = 0; tick();
    check("drain_head", rd_o, 10);
    check("stall_clear", stall_o, 1'b0);
    offer(20, 32'h5555_0000); tick();
    check("enq_deq_count", lq_count_o, 3);
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Reset mid-operation with three queued entries and a handshake in the reset cycle
    pipe(2'd0, 4);
    for (int i = 0; i < 3; i++) begin offer(REG_AW'(21 + i), 32'h7700_0000 + i); tick(); end
    rst = 1; offer(30, 32'hBAD0_0000); tick();
    rst = 0; idle();
    check("rst_mid_count", lq_count_o, 0);
    for (int i = 0; i < 4; i++) tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      wb_valid_i    = (m_starve >= STARVE_LIMIT && $urandom_range(0, 9) < 8) ? 1'b0
                                                                             : 1'($urandom);
      reg_write_i   = ($urandom_range(0, 3) != 0);
      result_src_i  = 2'($urandom);
      rd_i          = ($urandom_range(0, 7) == 0) ? '0 : REG_AW'($urandom);
      alu_result_i  = $urandom; read_data_i = $urandom;
      pc_plus4_i    = $urandom; imm_i = $urandom;
      load_funct3_i = 3'($urandom); addr_lo_i = 2'($urandom);
      late_valid_i  = ($urandom_range(0, 2) == 0);
      late_rd_i     = ($urandom_range(0, 7) == 0) ? '0 : REG_AW'($urandom);
      late_data_i   = $urandom;
      tick();
    end
    rst = 0; idle();
    for (int i = 0; i < 6; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
